// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, CTR sequencer states and default counter width.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned CTR_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_READY = 2'd3
  } ctr_state_e;

endpackage

// File: rtl/ctr_inc.sv
// Increment of the low-order counter field; the carry-out flags a rollover to zero.
module ctr_inc #(
  parameter int CTR_W = 32
) (
  input  logic [CTR_W-1:0] i_ctr,
  output logic [CTR_W-1:0] o_ctr,
  output logic             o_carry
);

  assign {o_carry, o_ctr} = {1'b0, i_ctr} + {{CTR_W{1'b0}}, 1'b1};

endmodule

// File: rtl/ctr_keystream_xor.sv
// CTR-mode sequencer around a single-block AES engine: issues counter blocks,
// captures the keystream and XORs it into a valid/ready stream of 128-bit blocks.
module ctr_keystream_xor
  import aes_pkg::*;
#(
  parameter int CTR_W = CTR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_BLK_W-1:0] iv_init,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 ctr_wrap,
  output logic [31:0]          blk_cnt,
  output logic                 enc_ld,
  output logic [AES_BLK_W-1:0] enc_iv,
  input  logic                 enc_done,
  input  logic [AES_BLK_W-1:0] enc_out
);

  ctr_state_e             r_state;
  ctr_state_e             w_state_nxt;
  logic [AES_BLK_W-1:0]   r_ctr;
  logic [AES_BLK_W-1:0]   r_ks;
  logic                   r_ks_valid;
  logic [AES_BLK_W-1:0]   r_out_data;
  logic                   r_out_valid;
  logic                   r_out_last;
  logic                   r_ctr_wrap;
  logic [31:0]            r_blk_cnt;
  logic                   r_enc_ld;
  logic                   w_in_ready;
  logic                   w_accept;
  logic [CTR_W-1:0]       w_ctr_lo_nxt;
  logic                   w_ctr_carry;

  // start wins over a coincident accept, so it also masks in_ready
  assign w_in_ready = (r_state == ST_READY) & r_ks_valid & (~r_out_valid | out_ready) & ~start;
  assign w_accept   = w_in_ready & in_valid;

  ctr_inc #(.CTR_W(CTR_W)) u_ctr_inc (
    .i_ctr   (r_ctr[CTR_W-1:0]),
    .o_ctr   (w_ctr_lo_nxt),
    .o_carry (w_ctr_carry)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_LOAD:  w_state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (enc_done) w_state_nxt = ST_READY;
          else          w_state_nxt = ST_WAIT;
        end
        ST_READY: begin
          if (w_accept) w_state_nxt = in_last ? ST_IDLE : ST_LOAD;
          else          w_state_nxt = ST_READY;
        end
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_enc_ld    <= 1'b0;
      r_ctr       <= {AES_BLK_W{1'b0}};
      r_ks        <= {AES_BLK_W{1'b0}};
      r_ks_valid  <= 1'b0;
      r_out_data  <= {AES_BLK_W{1'b0}};
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_ctr_wrap  <= 1'b0;
      r_blk_cnt   <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_enc_ld <= (w_state_nxt == ST_LOAD);
      if (start) begin
        r_ctr       <= iv_init;
        r_ks_valid  <= 1'b0;
        r_out_valid <= 1'b0;
        r_ctr_wrap  <= 1'b0;
        r_blk_cnt   <= 32'd0;
      end else begin
        if ((r_state == ST_WAIT) && enc_done) begin
          r_ks       <= enc_out;
          r_ks_valid <= 1'b1;
        end
        // enc_iv is r_ctr itself; it only moves after the engine result is in hand
        if (w_accept) begin
          r_out_data            <= in_data ^ r_ks;
          r_out_last            <= in_last;
          r_out_valid           <= 1'b1;
          r_ks_valid            <= 1'b0;
          r_blk_cnt             <= r_blk_cnt + 32'd1;
          r_ctr[CTR_W-1:0]      <= w_ctr_lo_nxt;
          r_ctr_wrap            <= r_ctr_wrap | w_ctr_carry;
        end else if (out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state != ST_IDLE) | r_out_valid;
  assign ctr_wrap  = r_ctr_wrap;
  assign blk_cnt   = r_blk_cnt;
  assign enc_ld    = r_enc_ld;
  assign enc_iv    = r_ctr;

endmodule

// File: tb/tb_ctr_keystream_xor.sv
// Scoreboard bench for ctr_keystream_xor with a behavioural AES engine stand-in.
module tb_ctr_keystream_xor;

  localparam logic [127:0] IV0   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] IV1   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] P1    = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1    = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] P2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2    = 128'h9806f66b7970fdff8617187bb9fffdff;
  localparam logic [127:0] KS1   = P1 ^ C1;
  localparam logic [127:0] KS2   = P2 ^ C2;
  localparam logic [127:0] IVB   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] IVW   = 128'h000000000000000000000001ffffffff;
  localparam logic [127:0] IVW_N = 128'h00000000000000000000000100000000;
  localparam logic [127:0] P3    = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] JUNK  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] iv_init = 128'd0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = 128'd0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         out_last;
  logic         busy;
  logic         ctr_wrap;
  logic [31:0]  blk_cnt;
  logic         enc_ld;
  logic [127:0] enc_iv;
  logic         enc_done = 1'b0;
  logic [127:0] enc_out = 128'd0;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [128:0] sb_q[$];
  logic [127:0] tb_ks = 128'd0;
  logic [127:0] eng_iv = 128'd0;
  logic [127:0] last_ld_iv = 128'd0;
  int           eng_cnt = 0;
  int           ld_cnt = 0;
  logic         inj_done = 1'b0;

  ctr_keystream_xor #(.CTR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .iv_init(iv_init),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .ctr_wrap(ctr_wrap), .blk_cnt(blk_cnt),
    .enc_ld(enc_ld), .enc_iv(enc_iv), .enc_done(enc_done), .enc_out(enc_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ks_of(input logic [127:0] iv);
    if (iv == IV0)      return KS1;
    else if (iv == IV1) return KS2;
    else                return {iv[63:0], iv[127:64]} ^ 128'hc3c35a5a0f0f9696c3c35a5a0f0f9696;
  endfunction

  // Engine stand-in: fixed latency after each launch, reload discards in-flight work
  always @(negedge clk) begin
    enc_done = 1'b0;
    if (rst) eng_cnt = 0;
    if (inj_done) begin
      enc_done = 1'b1;
      enc_out  = JUNK;
    end
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        check_val("enc_iv_stable", enc_iv, eng_iv);
        enc_done = 1'b1;
        enc_out  = ks_of(eng_iv);
        tb_ks    = enc_out;
      end
    end
    if (enc_ld && !rst) begin
      eng_iv     = enc_iv;
      last_ld_iv = enc_iv;
      eng_cnt    = 4;
      ld_cnt++;
    end
  end

  // Scoreboard: push on accept, pop and compare on drain
  always @(negedge clk) begin
    logic [128:0] e;
    if (rst || start) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_val("sb_unexpected_out", 128'(out_valid), 128'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("out_data", out_data, e[127:0]);
          check_val("out_last", 128'(out_last), 128'(e[128]));
        end
      end
      if (in_valid && in_ready) sb_q.push_back({in_last, in_data ^ tb_ks});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] iv);
    iv_init = iv;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input logic last);
    logic got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      got = in_ready;
      tick();
      if (got) break;
    end
    check_val("accept", 128'(got), 128'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    int bp_viol;
    int n_ld;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bp_viol;
    int n_ld;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check_val("rst_flags", 128'({in_ready, out_valid, out_last, busy, ctr_wrap, enc_ld}), 128'd0);
    check_val("rst_out_data", out_data, 128'd0);
    check_val("rst_enc_iv", enc_iv, 128'd0);
    check_val("rst_blk_cnt", 128'(blk_cnt), 128'd0);

    // F.5.1 vectors with 20 cycles of output backpressure after the first block
    out_ready = 1'b0;
    do_start(IV0);
    check_val("ld_pulse", 128'(enc_ld), 128'd1);
    check_val("ld_iv0", enc_iv, IV0);
    check_val("busy_load", 128'(busy), 128'd1);
    tick();
    check_val("ld_one_cycle", 128'(enc_ld), 128'd0);
    send(P1, 1'b0);
    check_val("blk_cnt_1", 128'(blk_cnt), 128'd1);
    in_valid = 1'b1;
    in_data  = P2;
    in_last  = 1'b0;
    bp_viol  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) bp_viol++;
      tick();
    end
    check_val("bp_no_accept", 128'(bp_viol), 128'd0);
    check_val("bp_hold_data", out_data, C1);
    check_val("bp_blk_cnt", 128'(blk_cnt), 128'd1);
    check_val("second_iv", last_ld_iv, IV1);
    out_ready = 1'b1;
    send(P2, 1'b0);
    check_val("c2_direct", out_data, C2);
    check_val("blk_cnt_2", 128'(blk_cnt), 128'd2);

    // Restart during WAIT with a stale engine pulse in the LOAD cycle
    for (int i = 0; i < 20; i++) begin
      if (ld_cnt >= 3) break;
      tick();
    end
    tick();
    do_start(IVB);
    inj_done = 1'b1;
    check_val("rs_ld", 128'(enc_ld), 128'd1);
    check_val("rs_iv", enc_iv, IVB);
    check_val("rs_blk_cnt", 128'(blk_cnt), 128'd0);
    check_val("rs_out_valid", 128'(out_valid), 128'd0);
    tick();
    inj_done = 1'b0;
    check_val("stale_ignored", 128'(in_ready), 128'd0);

    // Last block: no prefetch, busy holds until drained
    out_ready = 1'b0;
    send(P3, 1'b1);
    check_val("last_busy", 128'(busy), 128'd1);
    check_val("last_blk_cnt", 128'(blk_cnt), 128'd1);
    n_ld = ld_cnt;
    repeat (10) tick();
    check_val("no_prefetch", 128'(ld_cnt), 128'(n_ld));
    check_val("busy_hold", 128'(busy), 128'd1);
    out_ready = 1'b1;
    tick();
    check_val("busy_fall", 128'(busy), 128'd0);

    // Counter rollover in the low 32 bits
    do_start(IVW);
    send(P1, 1'b0);
    check_val("wrap_set", 128'(ctr_wrap), 128'd1);
    tick();
    check_val("wrap_iv", last_ld_iv, IVW_N);
    send(P2, 1'b1);
    tick();
    check_val("wrap_sticky", 128'(ctr_wrap), 128'd1);
    do_start(IV0);
    check_val("wrap_clr", 128'(ctr_wrap), 128'd0);

    // Asynchronous reset in READY, between clock edges
    for (int i = 0; i < 50; i++) begin
      if (in_ready) break;
      tick();
    end
    check_val("ready_before_rst", 128'(in_ready), 128'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_flags", 128'({in_ready, out_valid, out_last, busy, ctr_wrap, enc_ld}), 128'd0);
    check_val("arst_enc_iv", enc_iv, 128'd0);
    check_val("arst_out_data", out_data, 128'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    do_start(IV0);
    check_val("fresh_iv", enc_iv, IV0);
    send(P1, 1'b1);
    check_val("fresh_data", out_data, C1);
    check_val("fresh_blk_cnt", 128'(blk_cnt), 128'd1);
    repeat (5) tick();
    check_val("sb_drained", 128'(sb_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
